// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one physical memory port between the I-side and D-side.
// Define ARB_RR_EN for round-robin contention; otherwise D always wins contention.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [MASK_W-1:0] i_byte_enable,
   output logic              i_resp,
   output logic [DATA_W-1:0] i_rdata,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [MASK_W-1:0] d_byte_enable,
   output logic              d_resp,
   output logic [DATA_W-1:0] d_rdata,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_byte_enable,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_GRANT_I = 2'b01;
   localparam logic [1:0] ST_GRANT_D = 2'b10;

   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       last_grant;
   logic       last_grant_nxt;
   logic       i_req;
   logic       d_req;
   logic       d_wins;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
   // Contention goes to whichever side did not complete the previous transaction.
   assign d_wins = (last_grant == LG_I);
`else
   assign d_wins = 1'b1;
`endif

   // Read data is broadcast; only the matching resp qualifies it.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= LG_I;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state selection and combinational pass-through of the granted side.
   always_comb begin
      state_nxt       = state;
      last_grant_nxt  = last_grant;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      i_resp          = 1'b0;
      d_resp          = 1'b0;

      case (state)
         ST_IDLE: begin
            if (i_req && d_req) begin
               state_nxt = d_wins ? ST_GRANT_D : ST_GRANT_I;
            end else if (i_req) begin
               state_nxt = ST_GRANT_I;
            end else if (d_req) begin
               state_nxt = ST_GRANT_D;
            end
         end
         ST_GRANT_I: begin
            mem_read        = i_read & ~i_write;
            mem_write       = i_write;
            mem_address     = i_address;
            mem_wdata       = i_wdata;
            mem_byte_enable = i_byte_enable;
            if (mem_resp) begin
               i_resp         = 1'b1;
               state_nxt      = ST_IDLE;
               last_grant_nxt = LG_I;
            end
         end
         ST_GRANT_D: begin
            mem_read        = d_read & ~d_write;
            mem_write       = d_write;
            mem_address     = d_address;
            mem_wdata       = d_wdata;
            mem_byte_enable = d_byte_enable;
            if (mem_resp) begin
               d_resp         = 1'b1;
               state_nxt      = ST_IDLE;
               last_grant_nxt = LG_D;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
